// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg: minimal CCI-P Tx channel types used by the VAI audit stages
package ccip_if_pkg;
  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;
  typedef struct packed {
    logic [1:0]  vc_sel;
    logic        sop;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;
  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;
endpackage

// File: rtl/vai_audit_tx2_pkg.sv
// vai_audit_tx2_pkg: VMID tag geometry shared by the Tx and Rx audit stages
package vai_audit_tx2_pkg;
  localparam int VAI_MDATA_TAG_MSB = 15;
  function automatic int vai_vmid_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/vai_audit_tx_lane.sv
// vai_audit_tx_lane: one lane -- 3-stage Tx pipeline, VMID tagging, enable gating, saturating counters
module vai_audit_tx_lane
  import ccip_if_pkg::*;
  import vai_audit_tx2_pkg::*;
#(
  parameter int LANE = 0,
  parameter int NUM_SUB_AFUS = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_q,
  input  t_if_ccip_Tx          tx_in,
  input  logic                 enable,
  output t_if_ccip_Tx          tx_out,
  output logic [CNT_WIDTH-1:0] tag_err_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);
  localparam int VW = vai_vmid_width(NUM_SUB_AFUS);
  localparam int TM = VAI_MDATA_TAG_MSB;
  localparam logic [VW-1:0] VMID = VW'(LANE);
  logic reset_qq, en1, v0, v1;
  logic [1:0] tag, drop, tag2, drop2;
  t_if_ccip_Tx s1, a, s2;
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c, input logic [1:0] f);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, {1'b0, f[0]} + {1'b0, f[1]}};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction
  always_ff @(posedge clk) reset_qq <= reset_q;
  assign v0 = s1.c0.valid & en1;
  assign v1 = s1.c1.valid & en1;
  // a blocked request is only a drop, never also a tag error
  assign tag = {v1 & |s1.c1.hdr.mdata[TM -: VW], v0 & |s1.c0.hdr.mdata[TM -: VW]};
  assign drop = {s1.c1.valid & ~en1, s1.c0.valid & ~en1};
  always_comb begin
    a = '0;
    a.c0.valid = v0;
    a.c0.hdr = v0 ? s1.c0.hdr : '0;
    a.c0.hdr.mdata = v0 ? {VMID, s1.c0.hdr.mdata[TM-VW:0]} : '0;
    a.c1.valid = v1;
    a.c1.hdr = v1 ? s1.c1.hdr : '0;
    a.c1.hdr.mdata = v1 ? {VMID, s1.c1.hdr.mdata[TM-VW:0]} : '0;
    a.c1.data = v1 ? s1.c1.data : '0;
    a.c2.mmioRdValid = s1.c2.mmioRdValid;
    a.c2.hdr = s1.c2.mmioRdValid ? s1.c2.hdr : '0;
    a.c2.data = s1.c2.mmioRdValid ? s1.c2.data : '0;
  end
  always_ff @(posedge clk) begin
    if (reset_qq) begin
      s1 <= '0;
      en1 <= 1'b0;
      s2 <= '0;
      tag2 <= '0;
      drop2 <= '0;
      tx_out <= '0;
      tag_err_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      s1 <= tx_in;
      en1 <= enable;
      s2 <= a;
      tag2 <= tag;
      drop2 <= drop;
      tx_out <= s2;
      tag_err_cnt <= sat_add(tag_err_cnt, tag2);
      drop_cnt <= sat_add(drop_cnt, drop2);
    end
  end
endmodule

// File: rtl/vai_audit_tx2.sv
// vai_audit_tx2: Tx audit stage of the nested VAI mux -- one independent audit lane per sub-AFU
module vai_audit_tx2
  import ccip_if_pkg::*;
#(
  parameter int NUM_SUB_AFUS = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  t_if_ccip_Tx                           afu_TxPort [NUM_SUB_AFUS],
  output t_if_ccip_Tx                           up_TxPort [NUM_SUB_AFUS],
  input  logic [NUM_SUB_AFUS-1:0]               lane_enable,
  output logic [NUM_SUB_AFUS-1:0][CNT_WIDTH-1:0] tag_err_cnt,
  output logic [NUM_SUB_AFUS-1:0][CNT_WIDTH-1:0] drop_cnt
);
  logic reset_q;
  always_ff @(posedge clk) reset_q <= reset;
  for (genvar n = 0; n < NUM_SUB_AFUS; n++) begin : g_lane
    vai_audit_tx_lane #(
      .LANE(n),
      .NUM_SUB_AFUS(NUM_SUB_AFUS),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_lane (
      .clk(clk),
      .reset_q(reset_q),
      .tx_in(afu_TxPort[n]),
      .enable(lane_enable[n]),
      .tx_out(up_TxPort[n]),
      .tag_err_cnt(tag_err_cnt[n]),
      .drop_cnt(drop_cnt[n])
    );
  end
endmodule

// File: doc/vai_audit_tx2.md
Name: vai_audit_tx2

Overview:
- Transmit-side audit stage of the nested VAI multiplexer. Sits between the NUM_SUB_AFUS sub-AFU Tx ports and the upstream CCI-P Tx ports, one lane per sub-AFU.
- Each lane stamps its VMID into the top bits of c0/c1 request mdata. The Rx audit stage later uses those bits to route responses back to the lane.
- Each lane passes c2 MMIO read responses through unchanged and blocks requests from lanes that are quiesced.
- Each lane keeps saturating counters for tag violations and blocked requests.

Parameters:
- NUM_SUB_AFUS, 8: number of lanes. Must be >= 2.
- CNT_WIDTH, 16: width of each audit counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- afu_TxPort  in  t_if_ccip_Tx [NUM_SUB_AFUS]  Tx from sub-AFUs.
- up_TxPort  out  t_if_ccip_Tx [NUM_SUB_AFUS]  audited Tx toward upstream mux.
- lane_enable  in  [NUM_SUB_AFUS]  1 = lane may issue c0/c1 requests.
- tag_err_cnt  out  [NUM_SUB_AFUS][CNT_WIDTH]  per-lane tag-violation count.
- drop_cnt  out  [NUM_SUB_AFUS][CNT_WIDTH]  per-lane blocked-request count.

Behaviour:
- VMID_WIDTH = $clog2(NUM_SUB_AFUS). Lane n's VMID is n, truncated to VMID_WIDTH.
- Reset fanout:
  - reset registered once into reset_q, then into one reset_qq[n] per lane.
  - All lane state resets on reset_qq[n].
  - Upstream outputs are therefore forced idle from the 2nd cycle after reset assertion.
  - Reset mid-operation discards in-flight requests without emitting them.
- Reset values: all up_TxPort fields 0, including c0.valid, c1.valid and c2.mmioRdValid. Both counters 0.
- Pipeline, fixed 3-cycle latency from afu_TxPort[n] to up_TxPort[n] for every channel:
  - T1: register the lane's Tx.
  - T2: compute the tag-violation flag and the enable decision.
  - T3: drive the output.
  - Bubbles pass as bubbles; there is no reordering between channels.
- Tagging, c0 and c1 independently, only when the channel is valid:
  - Output mdata[15-:VMID_WIDTH] = n; output mdata[15-VMID_WIDTH:0] = input bits unchanged.
  - All other header fields and c1 data are unchanged.
- Tag violation: valid request whose input mdata[15-:VMID_WIDTH] != 0.
  - The request is still forwarded, tag overwritten as above.
  - tag_err_cnt[n] increments once per violating channel.
- Enable:
  - lane_enable[n] is sampled at T1, aligned with the request.
  - If 0, the c0/c1 request is emitted as valid=0 with header/data 0, and drop_cnt[n] increments per blocked channel.
  - If 0, c2 still passes, so MMIO reads never hang.
- c2: mmioRdValid, hdr (tid) and data are delayed 3 cycles, never modified, never blocked.
- Invalid channels: output header and data forced to 0 (clean upstream bus).
- Almost-full handling:
  - The upstream c0TxAlmFull/c1TxAlmFull is returned to AFUs by the Rx audit stage; this block only buffers.
  - Its 3-stage depth must be counted in the AFU almost-full slack.
  - No backpressure exists in this block.
- Counters:
  - Saturate at 2^CNT_WIDTH-1 and never wrap.
  - When both c0 and c1 violate (or are blocked) in the same cycle, the counter adds 2, saturating.
  - A request that is both blocked and tag-violating counts only in drop_cnt.
  - Counters update at T3; the output is registered.
- Lanes are fully independent; there is no cross-lane arbitration (the upstream mux arbitrates).

Decomposition:
- ccip_if_pkg supplies t_if_ccip_Tx, t_ccip_c0_ReqMemHdr, t_ccip_c1_ReqMemHdr and t_ccip_c2_RspMmioHdr.
- Add to the shared vai package:
  - function vai_vmid_width(n) returning $clog2(n), shared with the Rx audit stage;
  - constant VAI_MDATA_TAG_MSB = 15.
- Natural sub-module: vai_audit_tx_lane (one lane: pipeline, tagging, counters), instantiated NUM_SUB_AFUS times in a generate loop.

Test Plan:
- Tagging: lane 3, c0 read with mdata=0x0123, enabled → 3 cycles later up_TxPort[3].c0.valid=1, mdata=0x6123 (N=8); counters unchanged.
- Violation: lane 5, c1 write with mdata=0xE456, data=0xAA.. → output mdata=0xA456, data unchanged; tag_err_cnt[5]=1.
- Blocking: lane_enable[2]=0; c0 request and c2 rsp (tid=0x1F) in the same cycle → c0.valid=0 and c2 forwarded with tid=0x1F at +3; drop_cnt[2]=1.
- Dual-channel violation: c0 and c1 both with top bits set in one cycle → tag_err_cnt += 2. Preload near 0xFFFE → saturates at 0xFFFF.
- Reset mid-stream: requests on all lanes for 10 cycles, reset asserted on cycle 5 → outputs idle from cycle 7 and counters 0; no request issued before reset emerges after release.
- Isolation: back-to-back requests on all 8 lanes → each lane tagged with its own index; ordering and 3-cycle latency preserved per lane.
